// File: rtl/atuador_motores_pkg.sv
// Shared definitions for the cleaner-robot actuator stage.
// Holds the state encoding, the last-direction encoding, the default motion
// durations (reused by the navigation FSM bench) and the output decoder.
package atuador_motores_pkg;

  // Default durations in clock cycles
  localparam int unsigned T_AVANCO_PAD  = 8;
  localparam int unsigned T_GIRO_PAD    = 12;
  localparam int unsigned T_REMOCAO_PAD = 16;
  localparam int unsigned T_MORTO_PAD   = 2;
  localparam int unsigned CW_PAD        = 8;

  typedef enum logic [2:0] {
    StOcioso  = 3'd0,
    StMorto   = 3'd1,
    StAvanco  = 3'd2,
    StGiro    = 3'd3,
    StRemocao = 3'd4,
    StFim     = 3'd5
  } estado_t;

  // Direction class of the last completed wheel motion
  typedef enum logic [1:0] {
    DirNone = 2'd0,
    DirFwd  = 2'd1,
    DirTurn = 2'd2
  } ultima_dir_t;

  typedef struct packed {
    logic esq_fwd;
    logic esq_rev;
    logic dir_fwd;
    logic dir_rev;
    logic escova;
    logic ocupado;
    logic concluido;
  } saidas_t;

  // Output pattern for each state; anything unrecognised decodes to all-zero.
  function automatic saidas_t decodifica_saidas(estado_t estado);
    saidas_t s;
    s = '0;
    case (estado)
      StMorto: begin
        s.ocupado = 1'b1;
      end
      StAvanco: begin
        s.esq_fwd = 1'b1;
        s.dir_fwd = 1'b1;
        s.ocupado = 1'b1;
      end
      StGiro: begin
        // Right turn in place: left wheel forward, right wheel reverse
        s.esq_fwd = 1'b1;
        s.dir_rev = 1'b1;
        s.ocupado = 1'b1;
      end
      StRemocao: begin
        s.escova  = 1'b1;
        s.ocupado = 1'b1;
      end
      StFim: begin
        s.ocupado   = 1'b1;
        s.concluido = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/atuador_motores_temporizador_acao.sv
// temporizador_acao: CW-bit down-counter timing each motion phase.
// Ports:
//   clockc2     clock, rising edge
//   reset       synchronous, active-high; clears the count
//   carga       load valor into the counter (wins over decrement)
//   valor       load value
//   decrementa  decrement enable; saturates at zero, never wraps
//   zero        count is zero
module temporizador_acao #(
  parameter int unsigned CW = 8
) (
  input  logic          clockc2,
  input  logic          reset,
  input  logic          carga,
  input  logic [CW-1:0] valor,
  input  logic          decrementa,
  output logic          zero
);

  logic [CW-1:0] contagem_q, contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (carga) begin
      contagem_d = valor;
    end else if (decrementa && (contagem_q != '0)) begin
      contagem_d = contagem_q - 1'b1;
    end
  end

  always_ff @(posedge clockc2) begin
    if (reset) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign zero = (contagem_q == '0);

endmodule

// File: rtl/atuador_motores.sv
// atuador_motores: turns level motion commands into timed, self-contained
// motions (forward, right turn, brush sweep) and drives the H-bridge enables.
// Dead time is inserted whenever the wheel direction class changes.
// Ports:
//   clockc2, reset           clock and synchronous active-high reset
//   avancar, girar, remover  level requests, priority remover > girar > avancar
//   motor_esq_fwd/rev        left wheel H-bridge enables
//   motor_dir_fwd/rev        right wheel H-bridge enables
//   escova                   brush motor enable
//   ocupado                  motion in progress, requests ignored
//   concluido                one-cycle pulse at end of motion
module atuador_motores
  import atuador_motores_pkg::*;
#(
  parameter int unsigned T_AVANCO  = T_AVANCO_PAD,
  parameter int unsigned T_GIRO    = T_GIRO_PAD,
  parameter int unsigned T_REMOCAO = T_REMOCAO_PAD,
  parameter int unsigned T_MORTO   = T_MORTO_PAD,
  parameter int unsigned CW        = CW_PAD
) (
  input  logic clockc2,
  input  logic reset,
  input  logic avancar,
  input  logic girar,
  input  logic remover,
  output logic motor_esq_fwd,
  output logic motor_esq_rev,
  output logic motor_dir_fwd,
  output logic motor_dir_rev,
  output logic escova,
  output logic ocupado,
  output logic concluido
);

  localparam logic [CW-1:0] CargaAvanco  = CW'(T_AVANCO - 1);
  localparam logic [CW-1:0] CargaGiro    = CW'(T_GIRO - 1);
  localparam logic [CW-1:0] CargaRemocao = CW'(T_REMOCAO - 1);
  localparam logic [CW-1:0] CargaMorto   = CW'(T_MORTO - 1);

  estado_t     estado_q, estado_d;
  estado_t     alvo_q, alvo_d;          // action to enter once dead time expires
  ultima_dir_t ultima_dir_q, ultima_dir_d;
  saidas_t     saidas_q;

  logic          carga;
  logic [CW-1:0] valor;
  logic          decrementa;
  logic          zero;

  temporizador_acao #(
    .CW(CW)
  ) u_temporizador (
    .clockc2   (clockc2),
    .reset     (reset),
    .carga     (carga),
    .valor     (valor),
    .decrementa(decrementa),
    .zero      (zero)
  );

  always_comb begin
    estado_d     = estado_q;
    alvo_d       = alvo_q;
    ultima_dir_d = ultima_dir_q;
    carga        = 1'b0;
    valor        = '0;
    decrementa   = 1'b0;

    case (estado_q)
      StOcioso: begin
        if (remover) begin
          estado_d = StRemocao;
          carga    = 1'b1;
          valor    = CargaRemocao;
        end else if (girar) begin
          carga = 1'b1;
          if (ultima_dir_q == DirFwd) begin
            estado_d = StMorto;
            alvo_d   = StGiro;
            valor    = CargaMorto;
          end else begin
            estado_d = StGiro;
            valor    = CargaGiro;
          end
        end else if (avancar) begin
          carga = 1'b1;
          if (ultima_dir_q == DirTurn) begin
            estado_d = StMorto;
            alvo_d   = StAvanco;
            valor    = CargaMorto;
          end else begin
            estado_d = StAvanco;
            valor    = CargaAvanco;
          end
        end
      end
      StMorto: begin
        if (zero) begin
          carga = 1'b1;
          if (alvo_q == StGiro) begin
            estado_d = StGiro;
            valor    = CargaGiro;
          end else begin
            estado_d = StAvanco;
            valor    = CargaAvanco;
          end
        end else begin
          decrementa = 1'b1;
        end
      end
      StAvanco: begin
        if (zero) begin
          estado_d     = StFim;
          ultima_dir_d = DirFwd;
        end else begin
          decrementa = 1'b1;
        end
      end
      StGiro: begin
        if (zero) begin
          estado_d     = StFim;
          ultima_dir_d = DirTurn;
        end else begin
          decrementa = 1'b1;
        end
      end
      StRemocao: begin
        if (zero) begin
          estado_d     = StFim;
          ultima_dir_d = DirNone;
        end else begin
          decrementa = 1'b1;
        end
      end
      StFim: begin
        estado_d = StOcioso;
      end
      default: begin
        estado_d = StOcioso;
      end
    endcase
  end

  // Outputs are registered from the next state, so they line up with the
  // state register and never see an input combinationally.
  always_ff @(posedge clockc2) begin
    if (reset) begin
      estado_q     <= StOcioso;
      alvo_q       <= StAvanco;
      ultima_dir_q <= DirNone;
      saidas_q     <= '0;
    end else begin
      estado_q     <= estado_d;
      alvo_q       <= alvo_d;
      ultima_dir_q <= ultima_dir_d;
      saidas_q     <= decodifica_saidas(estado_d);
    end
  end

  assign motor_esq_fwd = saidas_q.esq_fwd;
  assign motor_esq_rev = saidas_q.esq_rev;
  assign motor_dir_fwd = saidas_q.dir_fwd;
  assign motor_dir_rev = saidas_q.dir_rev;
  assign escova        = saidas_q.escova;
  assign ocupado       = saidas_q.ocupado;
  assign concluido     = saidas_q.concluido;

endmodule

// File: tb/tb_atuador_motores.sv
// Directed bench for atuador_motores with hand-computed output patterns.
module tb_atuador_motores;

  logic clockc2;
  logic reset;
  logic avancar, girar, remover;
  logic motor_esq_fwd, motor_esq_rev, motor_dir_fwd, motor_dir_rev;
  logic escova, ocupado, concluido;

  int n_cmp = 0;
  int n_err = 0;
  logic fim_teste = 1'b0;
  logic concluido_ant = 1'b0;

  // Output vector order: esq_fwd esq_rev dir_fwd dir_rev escova ocupado concluido
  localparam logic [6:0] P_OCIOSO = 7'b0000000;
  localparam logic [6:0] P_MORTO  = 7'b0000010;
  localparam logic [6:0] P_AVANCO = 7'b1010010;
  localparam logic [6:0] P_GIRO   = 7'b1001010;
  localparam logic [6:0] P_REMOC  = 7'b0000110;
  localparam logic [6:0] P_FIM    = 7'b0000011;

  atuador_motores dut (
    .clockc2      (clockc2),
    .reset        (reset),
    .avancar      (avancar),
    .girar        (girar),
    .remover      (remover),
    .motor_esq_fwd(motor_esq_fwd),
    .motor_esq_rev(motor_esq_rev),
    .motor_dir_fwd(motor_dir_fwd),
    .motor_dir_rev(motor_dir_rev),
    .escova       (escova),
    .ocupado      (ocupado),
    .concluido    (concluido)
  );

  initial begin
    clockc2 = 1'b0;
    forever #5 clockc2 = ~clockc2;
  end

  task automatic compara(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_cmp++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  function automatic logic [6:0] saidas();
    return {motor_esq_fwd, motor_esq_rev, motor_dir_fwd, motor_dir_rev,
            escova, ocupado, concluido};
  endfunction

  task automatic tick();
    @(posedge clockc2);
    #1;
  endtask

  // Called in the first cycle after the request was accepted; checks the
  // dead-time cycles, the action cycles and stops in the FIM cycle.
  task automatic espera_movimento(input string tag, input int n_morto,
                                  input logic [6:0] padrao, input int t);
    for (int i = 0; i < n_morto; i++) begin
      compara({tag, "_morto"}, 32'(saidas()), 32'(P_MORTO));
      tick();
    end
    for (int i = 0; i < t; i++) begin
      compara({tag, "_acao"}, 32'(saidas()), 32'(padrao));
      tick();
    end
    compara({tag, "_fim"}, 32'(saidas()), 32'(P_FIM));
  endtask

  // Invariants every cycle outside reset
  always @(negedge clockc2) begin
    if (!reset && !fim_teste) begin
      compara("invariante",
              32'(!(motor_esq_fwd && motor_esq_rev) && !(motor_dir_fwd && motor_dir_rev) &&
                  !(escova && (motor_esq_fwd || motor_esq_rev ||
                               motor_dir_fwd || motor_dir_rev)) &&
                  !(concluido && concluido_ant)),
              32'd1);
    end
    concluido_ant = concluido;
  end

  initial begin
    reset   = 1'b1;
    avancar = 1'b0;
    girar   = 1'b0;
    remover = 1'b0;
    tick();
    tick();
    compara("reset", 32'(saidas()), 32'(P_OCIOSO));
    reset = 1'b0;
    tick();
    compara("ocioso", 32'(saidas()), 32'(P_OCIOSO));

    // 1: single forward from NONE, no dead time
    avancar = 1'b1;
    tick();
    avancar = 1'b0;
    espera_movimento("t1_avanco", 0, P_AVANCO, 8);
    tick();
    compara("t1_volta", 32'(saidas()), 32'(P_OCIOSO));

    // 2: turn after forward needs dead time
    girar = 1'b1;
    tick();
    girar = 1'b0;
    espera_movimento("t2_giro", 2, P_GIRO, 12);
    tick();
    compara("t2_volta", 32'(saidas()), 32'(P_OCIOSO));

    // 3: all requests -> remover wins; then held girar with no dead time
    avancar = 1'b1;
    girar   = 1'b1;
    remover = 1'b1;
    tick();
    avancar = 1'b0;
    girar   = 1'b0;
    remover = 1'b0;
    espera_movimento("t3_remocao", 0, P_REMOC, 16);
    girar = 1'b1;
    tick();
    compara("t3_ocioso", 32'(saidas()), 32'(P_OCIOSO));
    tick();
    girar = 1'b0;
    espera_movimento("t3_giro", 0, P_GIRO, 12);

    // 4: avancar held; first needs dead time (last TURN), second follows directly
    avancar = 1'b1;
    tick();
    compara("t4_ocioso0", 32'(saidas()), 32'(P_OCIOSO));
    tick();
    espera_movimento("t4_av1", 2, P_AVANCO, 8);
    tick();
    compara("t4_ocioso1", 32'(saidas()), 32'(P_OCIOSO));
    tick();
    for (int i = 0; i < 8; i++) begin
      compara("t4_av2", 32'(saidas()), 32'(P_AVANCO));
      girar = (i == 3);
      tick();
    end
    girar = 1'b0;
    compara("t4_fim", 32'(saidas()), 32'(P_FIM));
    avancar = 1'b0;
    tick();
    compara("t4_ocioso2", 32'(saidas()), 32'(P_OCIOSO));
    tick();
    compara("t4_ocioso3", 32'(saidas()), 32'(P_OCIOSO));

    // 5: reset in 5th GIRO cycle
    girar = 1'b1;
    tick();
    girar = 1'b0;
    for (int i = 0; i < 2; i++) begin
      compara("t5_morto", 32'(saidas()), 32'(P_MORTO));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      compara("t5_giro", 32'(saidas()), 32'(P_GIRO));
      tick();
    end
    compara("t5_giro5", 32'(saidas()), 32'(P_GIRO));
    reset = 1'b1;
    tick();
    compara("t5_reset", 32'(saidas()), 32'(P_OCIOSO));
    reset = 1'b0;
    avancar = 1'b1;
    tick();
    avancar = 1'b0;
    espera_movimento("t5_avanco", 0, P_AVANCO, 8);
    tick();
    compara("t5_volta", 32'(saidas()), 32'(P_OCIOSO));

    fim_teste = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
